// File: rtl/itrx_aib_phy_pkg.sv
// Shared encodings for the AIB PHY boundary-scan sequencer: FSM states and command opcodes.
package itrx_aib_phy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_SETUP   = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_HOLD    = 3'd4,
    ST_DONE    = 3'd5
  } bsr_state_t;

  localparam logic [1:0] OP_SHIFT      = 2'd0;
  localparam logic [1:0] OP_CAP_SHIFT  = 2'd1;
  localparam logic [1:0] OP_SET_MODE   = 2'd2;
  localparam logic [1:0] OP_SET_INTEST = 2'd3;

endpackage

// File: rtl/itrx_aib_phy_bsr_cnt.sv
// Shift-cycle counter: synchronous clear, count enable, terminal-count flag at TC_VAL.
module itrx_aib_phy_bsr_cnt #(
  parameter int CNT_W  = 8,
  parameter int TC_VAL = 31
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] LP_TC  = CNT_W'(TC_VAL);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + LP_ONE;
    end
  end

  assign o_tc = (r_cnt == LP_TC);

endmodule

// File: rtl/itrx_aib_phy_bsr_seq.sv
// Boundary-scan register sequencer: captures, shifts a CHAIN_LEN-bit pattern through the
// external cell chain and returns the bits shifted out; also owns the mode/intest broadcasts.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// CAPTURE | one clkdr pulse with scan_en low, cells capture parallel data
// SETUP   | scan_en high, no pulse, lets scan_en settle before shifting
// SHIFT   | CHAIN_LEN pulses with scan_en high, serial in/out
// HOLD    | scan_en still high, no pulse, quiet gap after the last shift
// DONE    | rsp_valid pulse, result published
module itrx_aib_phy_bsr_seq
  import itrx_aib_phy_pkg::*;
#(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic                 cmd_arg,
  input  logic [CHAIN_LEN-1:0] cmd_data,
  output logic                 rsp_valid,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 jtag_clkdr_en,
  output logic                 jtag_scan_en,
  output logic                 jtag_intest,
  output logic                 jtag_mode,
  output logic                 scan_si,
  input  logic                 scan_so
);

  bsr_state_t           r_state;
  logic [CHAIN_LEN-1:0] r_shreg;
  logic [CHAIN_LEN-1:0] r_rsp_data;
  logic                 r_rsp_valid;
  logic                 r_scan_en;
  logic                 r_clkdr_en;
  logic                 r_mode;
  logic                 r_intest;
  logic                 w_tc;

  // Counter is parked at zero whenever idle, so every scan starts from a clean count.
  itrx_aib_phy_bsr_cnt #(
    .CNT_W  (CNT_W),
    .TC_VAL (CHAIN_LEN - 1)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (r_state == ST_IDLE),
    .i_en  (r_state == ST_SHIFT),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shreg     <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_scan_en   <= 1'b0;
      r_clkdr_en  <= 1'b0;
      r_mode      <= 1'b0;
      r_intest    <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_SET_MODE: begin
                r_mode      <= cmd_arg;
                r_rsp_valid <= 1'b1;
                r_state     <= ST_DONE;
              end
              OP_SET_INTEST: begin
                r_intest    <= cmd_arg;
                r_rsp_valid <= 1'b1;
                r_state     <= ST_DONE;
              end
              OP_CAP_SHIFT: begin
                r_shreg    <= cmd_data;
                r_clkdr_en <= 1'b1;
                r_state    <= ST_CAPTURE;
              end
              default: begin
                r_shreg   <= cmd_data;
                r_scan_en <= 1'b1;
                r_state   <= ST_SETUP;
              end
            endcase
          end
        end
        ST_CAPTURE: begin
          r_scan_en  <= 1'b1;
          r_clkdr_en <= 1'b0;
          r_state    <= ST_SETUP;
        end
        ST_SETUP: begin
          r_clkdr_en <= 1'b1;
          r_state    <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_shreg <= {scan_so, r_shreg[CHAIN_LEN-1:1]};
          if (w_tc) begin
            r_clkdr_en <= 1'b0;
            r_state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          r_scan_en   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= r_shreg;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_scan_en  <= 1'b0;
          r_clkdr_en <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready     = (r_state == ST_IDLE);
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign jtag_clkdr_en = r_clkdr_en;
  assign jtag_scan_en  = r_scan_en;
  assign jtag_intest   = r_intest;
  assign jtag_mode     = r_mode;
  assign scan_si       = r_shreg[0];

endmodule

// File: tb/tb_itrx_aib_phy_bsr_seq.sv
// Bench for the boundary-scan sequencer with an 8-cell chain model behind a gated clkdr.
module tb_itrx_aib_phy_bsr_seq;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'd0;
  logic         cmd_arg = 1'b0;
  logic [N-1:0] cmd_data = '0;
  logic         rsp_valid;
  logic [N-1:0] rsp_data;
  logic         jtag_clkdr_en, jtag_scan_en, jtag_intest, jtag_mode;
  logic         scan_si, scan_so;

  itrx_aib_phy_bsr_seq #(.CHAIN_LEN(N), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .jtag_clkdr_en(jtag_clkdr_en), .jtag_scan_en(jtag_scan_en),
    .jtag_intest(jtag_intest), .jtag_mode(jtag_mode),
    .scan_si(scan_si), .scan_so(scan_so)
  );

  always #5 clk = ~clk;

  // External cell chain: clocked by the gated clkdr, serial in at the top, out at bit 0.
  logic [N-1:0] r_chain = '0;
  logic [N-1:0] d_i = '0;
  logic         s_clkdr = 1'b0, s_scan = 1'b0, s_si = 1'b0, s_intest = 1'b0;
  int           pulse_cnt = 0, zpulse_cnt = 0, rsp_seen = 0;
  logic [N-1:0] cell_out;

  assign scan_so  = r_chain[0];
  assign cell_out = jtag_mode ? r_chain : '0;

  always @(negedge clk) begin
    s_clkdr  <= jtag_clkdr_en;
    s_scan   <= jtag_scan_en;
    s_si     <= scan_si;
    s_intest <= jtag_intest;
    if (rsp_valid) rsp_seen <= rsp_seen + 1;
  end

  always @(posedge clk) begin
    if (s_clkdr) begin
      pulse_cnt <= pulse_cnt + 1;
      if (!s_scan) zpulse_cnt <= zpulse_cnt + 1;
      if (s_scan) r_chain <= {s_si, r_chain[N-1:1]};
      else if (s_intest) r_chain <= d_i;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: what the chain, the broadcasts and the response must be after each command.
  logic [N-1:0] m_chain = '0, m_rsp = '0;
  logic         m_mode = 1'b0, m_intest = 1'b0;

  task automatic model_step(input logic [1:0] op, input logic arg, input logic [N-1:0] data,
                            input logic [N-1:0] din, output logic [N-1:0] er, output int el,
                            output int ep, output int ez);
    case (op)
      2'd0: begin er = m_chain; m_chain = data; m_rsp = er; el = N + 3; ep = N; ez = 0; end
      2'd1: begin
        er = m_intest ? din : m_chain;
        m_chain = data; m_rsp = er; el = N + 4; ep = N + 1; ez = 1;
      end
      2'd2: begin m_mode = arg; er = m_rsp; el = 1; ep = 0; ez = 0; end
      default: begin m_intest = arg; er = m_rsp; el = 1; ep = 0; ez = 0; end
    endcase
  endtask

  // Starts and ends just after a rising edge.
  task automatic run_cmd(input logic [1:0] op, input logic arg, input logic [N-1:0] data,
                         input bit hold_busy, output logic [N-1:0] rsp, output int lat,
                         output int pulses, output int zp, output logic rv_after);
    int p0, z0, budget;
    cmd_op = op; cmd_arg = arg; cmd_data = data; cmd_valid = 1'b1;
    budget = 0;
    @(negedge clk);
    while (!cmd_ready && budget < 50) begin @(negedge clk); budget++; end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    p0 = pulse_cnt; z0 = zpulse_cnt;
    @(posedge clk); #1;
    if (hold_busy) begin cmd_op = 2'd2; cmd_arg = 1'b1; end
    else cmd_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 100) begin
      if (hold_busy) cmd_data = N'($urandom);
      @(negedge clk);
      lat++;
    end
    cmd_valid = 1'b0;
    rsp = rsp_data;
    pulses = pulse_cnt - p0;
    zp = zpulse_cnt - z0;
    @(posedge clk); #1;
    rv_after = rsp_valid;
  endtask

  typedef struct {
    logic [1:0]   op;
    logic         arg;
    logic [N-1:0] data;
    logic [N-1:0] din;
    logic [N-1:0] exp_rsp;
    int           exp_lat;
    int           exp_pulses;
    int           exp_zp;
    logic         exp_mode;
    logic         exp_intest;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] r, er;
    logic         rv;
    int           l, p, z, el, ep, ez, seen0;

    tbl[0] = '{2'd0, 1'b0, 8'hA5, 8'h00, 8'h00, 11, 8, 0, 1'b0, 1'b0};
    tbl[1] = '{2'd0, 1'b0, 8'h3C, 8'h00, 8'hA5, 11, 8, 0, 1'b0, 1'b0};
    tbl[2] = '{2'd3, 1'b1, 8'h00, 8'h00, 8'hA5, 1, 0, 0, 1'b0, 1'b1};
    tbl[3] = '{2'd1, 1'b0, 8'hFF, 8'h5A, 8'h5A, 12, 9, 1, 1'b0, 1'b1};
    tbl[4] = '{2'd2, 1'b1, 8'h00, 8'h00, 8'h5A, 1, 0, 0, 1'b1, 1'b1};
    tbl[5] = '{2'd2, 1'b0, 8'h12, 8'h00, 8'h5A, 1, 0, 0, 1'b0, 1'b1};
    tbl[6] = '{2'd3, 1'b0, 8'h00, 8'h00, 8'h5A, 1, 0, 0, 1'b0, 1'b0};
    tbl[7] = '{2'd1, 1'b0, 8'h81, 8'h77, 8'hFF, 12, 9, 1, 1'b0, 1'b0};
    tbl[8] = '{2'd0, 1'b0, 8'h00, 8'h00, 8'h81, 11, 8, 0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_mode", 32'(jtag_mode), 32'd0);
    check("rst_intest", 32'(jtag_intest), 32'd0);
    check("rst_scan_en", 32'(jtag_scan_en), 32'd0);
    check("rst_clkdr_en", 32'(jtag_clkdr_en), 32'd0);
    check("rst_scan_si", 32'(scan_si), 32'd0);

    for (int i = 0; i < 9; i++) begin
      d_i = tbl[i].din;
      model_step(tbl[i].op, tbl[i].arg, tbl[i].data, tbl[i].din, er, el, ep, ez);
      run_cmd(tbl[i].op, tbl[i].arg, tbl[i].data, 1'b0, r, l, p, z, rv);
      check($sformatf("vec%0d_rsp", i), 32'(r), 32'(tbl[i].exp_rsp));
      check($sformatf("vec%0d_lat", i), 32'(l), 32'(tbl[i].exp_lat));
      check($sformatf("vec%0d_pulses", i), 32'(p), 32'(tbl[i].exp_pulses));
      check($sformatf("vec%0d_capfirst", i), 32'(z), 32'(tbl[i].exp_zp));
      check($sformatf("vec%0d_mode", i), 32'(jtag_mode), 32'(tbl[i].exp_mode));
      check($sformatf("vec%0d_intest", i), 32'(jtag_intest), 32'(tbl[i].exp_intest));
      check($sformatf("vec%0d_rsp_once", i), 32'(rv), 32'd0);
      if (tbl[i].op == 2'd0 || tbl[i].op == 2'd1)
        check($sformatf("vec%0d_chain", i), 32'(r_chain), 32'(tbl[i].data));
      if (i == 4) check("mode_cell_out", 32'(cell_out), 32'hFF);
    end

    // Randomized commands against the model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]   op;
      logic         arg;
      logic [N-1:0] data;
      op = 2'($urandom_range(0, 3));
      arg = 1'($urandom);
      data = N'($urandom);
      d_i = N'($urandom);
      model_step(op, arg, data, d_i, er, el, ep, ez);
      run_cmd(op, arg, data, 1'b0, r, l, p, z, rv);
      check($sformatf("rnd%0d_rsp", i), 32'(r), 32'(er));
      check($sformatf("rnd%0d_lat", i), 32'(l), 32'(el));
      check($sformatf("rnd%0d_pulses", i), 32'(p), 32'(ep));
      check($sformatf("rnd%0d_capfirst", i), 32'(z), 32'(ez));
      check($sformatf("rnd%0d_mode", i), 32'(jtag_mode), 32'(m_mode));
      check($sformatf("rnd%0d_intest", i), 32'(jtag_intest), 32'(m_intest));
      check($sformatf("rnd%0d_chain", i), 32'(r_chain), 32'(m_chain));
      check($sformatf("rnd%0d_cell_out", i), 32'(cell_out), 32'(m_mode ? m_chain : '0));
    end

    // Busy-period command with churning data must be ignored.
    d_i = '0;
    model_step(2'd0, 1'b0, 8'h11, 8'h00, er, el, ep, ez);
    run_cmd(2'd0, 1'b0, 8'h11, 1'b1, r, l, p, z, rv);
    check("busy_rsp", 32'(r), 32'(er));
    check("busy_lat", 32'(l), 32'(N + 3));
    check("busy_chain", 32'(r_chain), 32'h11);
    check("busy_mode", 32'(jtag_mode), 32'(m_mode));
    check("busy_ready", 32'(cmd_ready), 32'd1);

    // Reset in the middle of a shift, with mode/intest/rsp_data all non-zero beforehand.
    model_step(2'd2, 1'b1, 8'h00, 8'h00, er, el, ep, ez);
    run_cmd(2'd2, 1'b1, 8'h00, 1'b0, r, l, p, z, rv);
    model_step(2'd3, 1'b1, 8'h00, 8'h00, er, el, ep, ez);
    run_cmd(2'd3, 1'b1, 8'h00, 1'b0, r, l, p, z, rv);
    cmd_op = 2'd0; cmd_data = 8'h5F; cmd_valid = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    seen0 = rsp_seen;
    rst = 1'b1;
    #1;
    check("abort_scan_en", 32'(jtag_scan_en), 32'd0);
    check("abort_clkdr_en", 32'(jtag_clkdr_en), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_rsp_data", 32'(rsp_data), 32'd0);
    check("abort_mode", 32'(jtag_mode), 32'd0);
    check("abort_intest", 32'(jtag_intest), 32'd0);
    check("abort_scan_si", 32'(scan_si), 32'd0);
    check("abort_ready_rst", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (N + 6) @(posedge clk);
    #1;
    check("abort_no_rsp", 32'(rsp_seen - seen0), 32'd0);
    m_mode = 1'b0; m_intest = 1'b0; m_rsp = '0; m_chain = r_chain;
    model_step(2'd0, 1'b0, 8'hC3, 8'h00, er, el, ep, ez);
    run_cmd(2'd0, 1'b0, 8'hC3, 1'b0, r, l, p, z, rv);
    check("post_abort_rsp", 32'(r), 32'(er));
    check("post_abort_lat", 32'(l), 32'(el));
    check("post_abort_pulses", 32'(p), 32'(ep));
    check("post_abort_chain", 32'(r_chain), 32'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
